// File: rtl/add_step_ctrl.sv
// rtl/add_step_ctrl.sv - up/down step counter sequencer that shares one external 8-bit add/sub stage
// Optional signed counting is built when ADD_STEP_SIGNED_EN is defined.
module add_step_ctrl #(
  parameter logic [7:0] STEP_DEF  = 8'd1,
  parameter logic [7:0] LIMIT_DEF = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       en,
  input  logic       dir,
  input  logic       sat,
`ifdef ADD_STEP_SIGNED_EN
  input  logic       signed_mode,
`endif
  output logic [7:0] add_x,
  output logic [7:0] add_y,
  output logic       add_cin,
  input  logic [7:0] add_result,
  input  logic       add_carry,
  input  logic       add_overflow,
  output logic [7:0] count,
  output logic       tc,
  output logic       ovf,
  output logic       cnt_zero
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD      = 2'b00;
  localparam logic [1:0] OP_SET_STEP  = 2'b01;
  localparam logic [1:0] OP_SET_LIMIT = 2'b10;
  localparam logic [1:0] OP_CLEAR     = 2'b11;

  state_t     state, state_nxt;
  logic [7:0] step, limit;
  logic       dir_r, sat_r, wrap_r, sgn_r;

  logic       wrap, ge, floor_hit, terminal;
  logic [7:0] clamp, term_count;

`ifdef ADD_STEP_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_r <= 1'b0;
    end else if (state == ST_IDLE && !cmd_valid && en) begin
      sgn_r <= signed_mode;
    end
  end
`else
  assign sgn_r = 1'b0;
`endif

  // STEP and CHECK both read the shared adder; these decode its outputs per phase.
  assign wrap      = sgn_r ? add_overflow : (dir_r ? ~add_carry : add_carry);
  assign clamp     = sgn_r ? (dir_r ? 8'h80 : 8'h7F) : (dir_r ? 8'h00 : 8'hFF);
  assign ge        = sgn_r ? ~(add_result[7] ^ add_overflow) : add_carry;
  assign floor_hit = (count == (sgn_r ? 8'h80 : 8'h00));
  assign terminal  = dir_r ? (wrap_r | floor_hit) : ge;
  assign term_count = dir_r ? (sat_r ? count : limit) : (sat_r ? limit : 8'h00);

  assign cnt_zero = (count == 8'h00);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    add_x     = count;
    add_y     = 8'h00;
    add_cin   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (!cmd_valid && en) state_nxt = ST_STEP;
      end
      ST_STEP: begin
        add_y     = step;
        add_cin   = dir_r;
        state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        add_y     = limit;
        add_cin   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      count  <= 8'h00;
      step   <= STEP_DEF;
      limit  <= LIMIT_DEF;
      tc     <= 1'b0;
      ovf    <= 1'b0;
      dir_r  <= 1'b0;
      sat_r  <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      state <= state_nxt;
      tc    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_LOAD:      count <= cmd_data;
              OP_SET_STEP:  step  <= cmd_data;
              OP_SET_LIMIT: limit <= cmd_data;
              OP_CLEAR: begin
                count <= 8'h00;
                ovf   <= 1'b0;
              end
              default: ;
            endcase
          end else if (en) begin
            dir_r <= dir;
            sat_r <= sat;
          end
        end
        ST_STEP: begin
          wrap_r <= wrap;
          if (wrap) ovf <= 1'b1;
          count <= (wrap && sat_r) ? clamp : add_result;
        end
        ST_CHECK: begin
          if (terminal) begin
            tc    <= 1'b1;
            count <= term_count;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
